// File: rtl/cp_insert.sv
// Cyclic-prefix insertion for IFFT output through a ping-pong sample buffer; FFT mode is a 1-cycle pass-through.
// Build option: define CP_INSERT_OVF_EN for the sticky dout_ovf flag, otherwise dout_ovf is tied low.
module cp_insert #(
   parameter int DATA_NBIT = 15
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 fft_type,
   input  logic                 cp_type,
   input  logic [2:0]           fft_num,
   input  logic                 din_fst,
   input  logic                 din_sop,
   input  logic                 din_eop,
   input  logic                 din_valid,
   input  logic [DATA_NBIT-1:0] din_real,
   input  logic [DATA_NBIT-1:0] din_imag,
   output logic [DATA_NBIT-1:0] dout_i,
   output logic [DATA_NBIT-1:0] dout_q,
   output logic                 dout_v,
   output logic                 dout_h,
   output logic                 dout_s,
   output logic                 dout_ovf
);
   localparam int AW = 11;
   localparam int MW = 2*DATA_NBIT;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CP   = 2'd1;
   localparam logic [1:0] S_BODY = 2'd2;

   // write side
   logic          r_wr_bank;
   logic [AW-1:0] r_wr_addr;
   logic [11:0]   r_wr_n;
   logic [11:0]   r_wr_l;
   logic          r_wr_fst;

   // read side
   logic [1:0]    r_state;
   logic [11:0]   r_rd_cnt;
   logic [11:0]   r_rd_n;
   logic [11:0]   r_rd_l;
   logic          r_rd_fst;
   logic          r_rd_bank;

   // buffer and read pipeline
   logic [MW-1:0] r_mem [0:4095];
   logic [MW-1:0] r_rd_data;
   logic [AW:0]   r_rd_addr;
   logic [1:0]    r_vld_pipe;
   logic [1:0]    r_hdr_pipe;
   logic [1:0]    r_fst_pipe;

   logic          w_in_v;
   logic          w_sop;
   logic          w_eop;
   logic          w_wr_en;
   logic [AW-1:0] w_wr_addr;
   logic [11:0]   w_n_new;
   logic [11:0]   w_l_new;
   logic [11:0]   w_n_cur;
   logic [11:0]   w_l_cur;
   logic          w_fst_cur;
   logic          w_rd_last;
   logic          w_rd_free;
   logic          w_handoff;
   logic [AW-1:0] w_rd_addr;

   assign w_in_v    = din_valid & fft_type;
   assign w_sop     = w_in_v & din_sop;
   assign w_eop     = w_in_v & din_eop;
   assign w_wr_en   = w_in_v & ~reset;
   assign w_wr_addr = w_sop ? '0 : r_wr_addr;

   assign w_n_new = 12'd2048 >> fft_num;
   assign w_l_new = cp_type ? (12'd512 >> fft_num) :
                    din_fst ? (12'd160 >> fft_num) : (12'd144 >> fft_num);

   // a symbol that is one sample long hands off the values it latches this same cycle
   assign w_n_cur   = w_sop ? w_n_new : r_wr_n;
   assign w_l_cur   = w_sop ? w_l_new : r_wr_l;
   assign w_fst_cur = w_sop ? din_fst : r_wr_fst;

   // the reader finishing on this cycle counts as free, so symbols can run back to back
   assign w_rd_last = (r_state == S_BODY) && (r_rd_cnt == r_rd_n - 12'd1);
   assign w_rd_free = (r_state == S_IDLE) || w_rd_last;
   assign w_handoff = w_eop & w_rd_free;

   assign w_rd_addr = (r_state == S_CP) ? AW'(r_rd_n - r_rd_l + r_rd_cnt) : AW'(r_rd_cnt);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_bank <= 1'b0;
         r_wr_addr <= '0;
         r_wr_n    <= 12'd2048;
         r_wr_l    <= 12'd144;
         r_wr_fst  <= 1'b0;
      end else if (w_in_v) begin
         if (din_sop) begin
            r_wr_n   <= w_n_new;
            r_wr_l   <= w_l_new;
            r_wr_fst <= din_fst;
         end
         r_wr_addr <= (w_wr_addr == '1) ? w_wr_addr : w_wr_addr + 1'b1;
         if (w_handoff)
            r_wr_bank <= ~r_wr_bank;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en)
         r_mem[{r_wr_bank, w_wr_addr}] <= {din_real, din_imag};
      r_rd_data <= r_mem[r_rd_addr];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_rd_cnt  <= '0;
         r_rd_n    <= 12'd2048;
         r_rd_l    <= 12'd144;
         r_rd_fst  <= 1'b0;
         r_rd_bank <= 1'b0;
      end else if (!fft_type) begin
         r_state  <= S_IDLE;
         r_rd_cnt <= '0;
      end else if (w_handoff) begin
         r_state   <= S_CP;
         r_rd_cnt  <= '0;
         r_rd_n    <= w_n_cur;
         r_rd_l    <= w_l_cur;
         r_rd_fst  <= w_fst_cur;
         r_rd_bank <= r_wr_bank;
      end else begin
         case (r_state)
            S_CP: begin
               if (r_rd_cnt == r_rd_l - 12'd1) begin
                  r_state  <= S_BODY;
                  r_rd_cnt <= '0;
               end else begin
                  r_rd_cnt <= r_rd_cnt + 12'd1;
               end
            end
            S_BODY: begin
               if (w_rd_last) begin
                  r_state  <= S_IDLE;
                  r_rd_cnt <= '0;
               end else begin
                  r_rd_cnt <= r_rd_cnt + 12'd1;
               end
            end
            default: begin
               r_state  <= S_IDLE;
               r_rd_cnt <= '0;
            end
         endcase
      end
   end

   // stage 0: address register, stage 1: buffer read, then the output register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_addr  <= '0;
         r_vld_pipe <= '0;
         r_hdr_pipe <= '0;
         r_fst_pipe <= '0;
      end else begin
         r_rd_addr  <= {r_rd_bank, w_rd_addr};
         r_vld_pipe <= {r_vld_pipe[0], r_state != S_IDLE};
         r_hdr_pipe <= {r_hdr_pipe[0], (r_state == S_CP) && (r_rd_cnt == 12'd0)};
         r_fst_pipe <= {r_fst_pipe[0], r_rd_fst};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dout_i <= '0;
         dout_q <= '0;
         dout_v <= 1'b0;
         dout_h <= 1'b0;
         dout_s <= 1'b0;
      end else if (!fft_type) begin
         dout_v <= din_valid;
         dout_h <= din_valid & din_sop;
         dout_s <= din_fst;
         if (din_valid) begin
            dout_i <= din_real;
            dout_q <= din_imag;
         end
      end else begin
         dout_v <= r_vld_pipe[1];
         dout_h <= r_hdr_pipe[1];
         dout_s <= r_vld_pipe[1] & r_fst_pipe[1];
         if (r_vld_pipe[1]) begin
            dout_i <= r_rd_data[MW-1:DATA_NBIT];
            dout_q <= r_rd_data[DATA_NBIT-1:0];
         end
      end
   end

`ifdef CP_INSERT_OVF_EN
   logic w_ovf_evt;
   logic r_ovf;

   assign w_ovf_evt = w_eop & ~w_rd_free;

   always_ff @(posedge clk) begin
      if (reset)
         r_ovf <= 1'b0;
      else if (w_ovf_evt)
         r_ovf <= 1'b1;
   end

   assign dout_ovf = r_ovf;
`else
   assign dout_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_cp_insert.sv
// Directed bench for cp_insert: CP insertion at several sizes, back-to-back, overflow drop, pass-through and reset.
`timescale 1ns/1ps
module tb_cp_insert;
   localparam int DW = 15;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          fft_type = 1'b0;
   logic          cp_type = 1'b0;
   logic [2:0]    fft_num = 3'd0;
   logic          din_fst = 1'b0;
   logic          din_sop = 1'b0;
   logic          din_eop = 1'b0;
   logic          din_valid = 1'b0;
   logic [DW-1:0] din_real = '0;
   logic [DW-1:0] din_imag = '0;
   logic [DW-1:0] dout_i;
   logic [DW-1:0] dout_q;
   logic          dout_v;
   logic          dout_h;
   logic          dout_s;
   logic          dout_ovf;

   int cyc = 0;
   int vec = 0;
   int miss = 0;
   int cap_cyc[$];
   logic [DW-1:0] cap_i[$];
   logic [DW-1:0] cap_q[$];
   logic cap_h[$];
   logic cap_s[$];
   logic [DW-1:0] exp_i[$];
   logic [DW-1:0] exp_q[$];
   logic exp_ovf;

   cp_insert #(.DATA_NBIT(DW)) dut (
      .clk(clk), .reset(reset), .fft_type(fft_type), .cp_type(cp_type), .fft_num(fft_num),
      .din_fst(din_fst), .din_sop(din_sop), .din_eop(din_eop), .din_valid(din_valid),
      .din_real(din_real), .din_imag(din_imag), .dout_i(dout_i), .dout_q(dout_q),
      .dout_v(dout_v), .dout_h(dout_h), .dout_s(dout_s), .dout_ovf(dout_ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (dout_v === 1'b1) begin
         cap_cyc.push_back(cyc);
         cap_i.push_back(dout_i);
         cap_q.push_back(dout_q);
         cap_h.push_back(dout_h);
         cap_s.push_back(dout_s);
      end
   end

   function automatic logic [DW-1:0] f_re(int base, int k);
      return DW'(base + k);
   endfunction

   function automatic logic [DW-1:0] f_im(int base, int k);
      return DW'(k * 3 + base + 5);
   endfunction

   task automatic clear_cap();
      cap_cyc.delete(); cap_i.delete(); cap_q.delete(); cap_h.delete(); cap_s.delete();
      exp_i.delete(); exp_q.delete();
   endtask

   task automatic build_exp(int n, int l, int base);
      for (int k = 0; k < l; k++) begin
         exp_i.push_back(f_re(base, n - l + k));
         exp_q.push_back(f_im(base, n - l + k));
      end
      for (int k = 0; k < n; k++) begin
         exp_i.push_back(f_re(base, k));
         exp_q.push_back(f_im(base, k));
      end
   endtask

   task automatic idle(int n);
      repeat (n) begin
         @(posedge clk); #1;
         din_valid = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
      end
   endtask

   // eop_cyc is the cycle stamp of the clock edge that accepts the last sample
   task automatic send_sym(int n, logic fst, int base, logic with_sop, output int eop_cyc);
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         din_valid = 1'b1;
         din_sop   = with_sop && (k == 0);
         din_eop   = (k == n - 1);
         din_fst   = fst;
         din_real  = f_re(base, k);
         din_imag  = f_im(base, k);
         if (k == n - 1) eop_cyc = cyc + 1;
      end
      idle(1);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1; din_valid = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      clear_cap();
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      reset = 1'b1; fft_type = 1'b0; din_valid = 1'b1; din_sop = 1'b1; din_fst = 1'b1;
      din_real = 15'h1234; din_imag = 15'h4321;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vec++;
      if ({dout_v, dout_h, dout_s, dout_ovf} !== 4'b0) begin
         miss++; $display("FAIL rst_flags: got v/h/s/ovf=%b want 0000", {dout_v, dout_h, dout_s, dout_ovf});
      end
      vec++;
      if (dout_i !== '0 || dout_q !== '0) begin
         miss++; $display("FAIL rst_data: got i=%h q=%h want 0/0", dout_i, dout_q);
      end
      @(posedge clk); #1;
      reset = 1'b0; din_valid = 1'b0; din_sop = 1'b0; din_fst = 1'b0;
      clear_cap();
   endtask

   // no sop after reset: the handoff must use the reset values N=2048, L=144, fst=0
   task automatic test_reset_defaults();
      int e, bad, first, c0;
      do_reset();
      fft_type = 1'b1; fft_num = 3'd4; cp_type = 1'b1;
      send_sym(2048, 1'b1, 11, 1'b0, e);
      build_exp(2048, 144, 11);
      repeat (2220) @(posedge clk);
      vec++;
      if (cap_i.size() != 2192) begin
         miss++; $display("FAIL dflt_count: got %0d samples want 2192", cap_i.size());
      end
      c0 = (cap_cyc.size() > 0) ? cap_cyc[0] : -1;
      vec++;
      if (c0 != e + 3) begin
         miss++; $display("FAIL dflt_latency: got first at %0d want %0d", c0, e + 3);
      end
      bad = 0; first = -1;
      for (int k = 0; k < cap_i.size() && k < exp_i.size(); k++)
         if (cap_i[k] !== exp_i[k] || cap_q[k] !== exp_q[k] || cap_s[k] !== 1'b0) begin
            bad++; if (first < 0) first = k;
         end
      vec++;
      if (bad != 0) begin
         miss++; $display("FAIL dflt_data: %0d bad, first idx %0d got %h want %h", bad, first, cap_i[first], exp_i[first]);
      end
   endtask

   task automatic test_ifft_2048();
      int e, bad, first, hc, c0, span;
      do_reset();
      fft_type = 1'b1; fft_num = 3'd0; cp_type = 1'b0;
      send_sym(2048, 1'b1, 0, 1'b1, e);
      build_exp(2048, 160, 0);
      repeat (2240) @(posedge clk);
      vec++;
      if (cap_i.size() != 2208) begin
         miss++; $display("FAIL n2048_count: got %0d samples want 2208", cap_i.size());
      end
      c0   = (cap_cyc.size() > 0) ? cap_cyc[0] : -1;
      span = (cap_cyc.size() > 0) ? cap_cyc[$] - cap_cyc[0] + 1 : 0;
      vec++;
      if (c0 != e + 3) begin
         miss++; $display("FAIL n2048_latency: got first at %0d want %0d", c0, e + 3);
      end
      vec++;
      if (span != 2208) begin
         miss++; $display("FAIL n2048_contig: got span %0d want 2208", span);
      end
      bad = 0; first = -1; hc = 0;
      for (int k = 0; k < cap_i.size() && k < exp_i.size(); k++) begin
         if (cap_i[k] !== exp_i[k] || cap_q[k] !== exp_q[k] || cap_s[k] !== 1'b1) begin
            bad++; if (first < 0) first = k;
         end
         if (cap_h[k] === 1'b1) hc++;
      end
      vec++;
      if (bad != 0) begin
         miss++; $display("FAIL n2048_data: %0d bad, first idx %0d got %h want %h", bad, first, cap_i[first], exp_i[first]);
      end
      vec++;
      if (hc != 1 || cap_h.size() == 0 || cap_h[0] !== 1'b1) begin
         miss++; $display("FAIL n2048_hdr: got %0d headers want 1 on first sample", hc);
      end
      @(negedge clk);
      vec++;
      if (dout_i !== f_re(0, 2047) || dout_v !== 1'b0) begin
         miss++; $display("FAIL n2048_hold: got i=%h v=%b want %h/0", dout_i, dout_v, f_re(0, 2047));
      end
   endtask

   task automatic test_ifft_128_ext();
      int e, bad, first, c0;
      do_reset();
      fft_type = 1'b1; fft_num = 3'd4; cp_type = 1'b1;
      send_sym(128, 1'b0, 0, 1'b1, e);
      build_exp(128, 32, 0);
      repeat (200) @(posedge clk);
      vec++;
      if (cap_i.size() != 160) begin
         miss++; $display("FAIL n128_count: got %0d samples want 160", cap_i.size());
      end
      c0 = (cap_cyc.size() > 0) ? cap_cyc[0] : -1;
      vec++;
      if (c0 != e + 3) begin
         miss++; $display("FAIL n128_latency: got first at %0d want %0d", c0, e + 3);
      end
      bad = 0; first = -1;
      for (int k = 0; k < cap_i.size() && k < exp_i.size(); k++)
         if (cap_i[k] !== exp_i[k] || cap_q[k] !== exp_q[k] || cap_s[k] !== 1'b0) begin
            bad++; if (first < 0) first = k;
         end
      vec++;
      if (bad != 0) begin
         miss++; $display("FAIL n128_data: %0d bad, first idx %0d got %h want %h", bad, first, cap_i[first], exp_i[first]);
      end
   endtask

   task automatic test_back_to_back();
      int e1, e2, bad, first, hc, span;
      do_reset();
      fft_type = 1'b1; fft_num = 3'd2; cp_type = 1'b0;
      send_sym(512, 1'b0, 0, 1'b1, e1);
      idle(35);
      send_sym(512, 1'b0, 1000, 1'b1, e2);
      build_exp(512, 36, 0);
      build_exp(512, 36, 1000);
      repeat (600) @(posedge clk);
      vec++;
      if (e2 - e1 != 548) begin
         miss++; $display("FAIL b2b_stim: got eop gap %0d want 548", e2 - e1);
      end
      vec++;
      if (cap_i.size() != 1096) begin
         miss++; $display("FAIL b2b_count: got %0d samples want 1096", cap_i.size());
      end
      span = (cap_cyc.size() > 0) ? cap_cyc[$] - cap_cyc[0] + 1 : 0;
      vec++;
      if (span != 1096) begin
         miss++; $display("FAIL b2b_contig: got span %0d want 1096", span);
      end
      bad = 0; first = -1; hc = 0;
      for (int k = 0; k < cap_i.size() && k < exp_i.size(); k++) begin
         if (cap_i[k] !== exp_i[k] || cap_q[k] !== exp_q[k]) begin
            bad++; if (first < 0) first = k;
         end
         if (cap_h[k] === 1'b1) hc++;
      end
      vec++;
      if (bad != 0) begin
         miss++; $display("FAIL b2b_data: %0d bad, first idx %0d got %h want %h", bad, first, cap_i[first], exp_i[first]);
      end
      vec++;
      if (hc != 2 || cap_h.size() < 549 || cap_h[548] !== 1'b1) begin
         miss++; $display("FAIL b2b_hdr: got %0d headers want 2 at idx 0 and 548", hc);
      end
      vec++;
      if (dout_ovf !== 1'b0) begin
         miss++; $display("FAIL b2b_ovf: got %b want 0", dout_ovf);
      end
   endtask

   task automatic test_overflow();
      int e1, e2, bad, first, span;
      do_reset();
      fft_type = 1'b1; fft_num = 3'd2; cp_type = 1'b0;
      send_sym(512, 1'b1, 0, 1'b1, e1);
      idle(49);
      send_sym(50, 1'b0, 3000, 1'b1, e2);
      build_exp(512, 40, 0);
      repeat (600) @(posedge clk);
      vec++;
      if (cap_i.size() != 552 || e2 - e1 != 100) begin
         miss++; $display("FAIL ovf_count: got %0d samples (eop gap %0d) want 552 (100)", cap_i.size(), e2 - e1);
      end
      span = (cap_cyc.size() > 0) ? cap_cyc[$] - cap_cyc[0] + 1 : 0;
      vec++;
      if (span != 552) begin
         miss++; $display("FAIL ovf_contig: got span %0d want 552", span);
      end
      bad = 0; first = -1;
      for (int k = 0; k < cap_i.size() && k < exp_i.size(); k++)
         if (cap_i[k] !== exp_i[k] || cap_q[k] !== exp_q[k] || cap_s[k] !== 1'b1) begin
            bad++; if (first < 0) first = k;
         end
      vec++;
      if (bad != 0) begin
         miss++; $display("FAIL ovf_data: %0d bad, first idx %0d got %h want %h", bad, first, cap_i[first], exp_i[first]);
      end
      vec++;
      if (dout_ovf !== exp_ovf) begin
         miss++; $display("FAIL ovf_flag: got %b want %b", dout_ovf, exp_ovf);
      end
   endtask

   task automatic test_fft_passthrough();
      int e, bad, first, hc, c0, span;
      do_reset();
      fft_type = 1'b0; fft_num = 3'd3; cp_type = 1'b0;
      send_sym(256, 1'b1, 7, 1'b1, e);
      for (int k = 0; k < 256; k++) begin
         exp_i.push_back(f_re(7, k));
         exp_q.push_back(f_im(7, k));
      end
      repeat (10) @(posedge clk);
      vec++;
      if (cap_i.size() != 256) begin
         miss++; $display("FAIL fft_count: got %0d samples want 256", cap_i.size());
      end
      c0   = (cap_cyc.size() > 0) ? cap_cyc[0] : -1;
      span = (cap_cyc.size() > 0) ? cap_cyc[$] - cap_cyc[0] + 1 : 0;
      vec++;
      if (c0 != e - 255 || span != 256) begin
         miss++; $display("FAIL fft_timing: got first %0d span %0d want %0d/256", c0, span, e - 255);
      end
      bad = 0; first = -1; hc = 0;
      for (int k = 0; k < cap_i.size() && k < exp_i.size(); k++) begin
         if (cap_i[k] !== exp_i[k] || cap_q[k] !== exp_q[k] || cap_s[k] !== 1'b1) begin
            bad++; if (first < 0) first = k;
         end
         if (cap_h[k] === 1'b1) hc++;
      end
      vec++;
      if (bad != 0) begin
         miss++; $display("FAIL fft_data: %0d bad, first idx %0d got %h want %h", bad, first, cap_i[first], exp_i[first]);
      end
      vec++;
      if (hc != 1 || cap_h.size() == 0 || cap_h[0] !== 1'b1) begin
         miss++; $display("FAIL fft_hdr: got %0d headers want 1 on first sample", hc);
      end
      vec++;
      if (dout_i !== f_re(7, 255) || dout_q !== f_im(7, 255)) begin
         miss++; $display("FAIL fft_hold: got %h/%h want %h/%h", dout_i, dout_q, f_re(7, 255), f_im(7, 255));
      end
   endtask

   task automatic test_reset_mid();
      int e, t, bad, first, c0;
      do_reset();
      fft_type = 1'b1; fft_num = 3'd0; cp_type = 1'b0;
      send_sym(2048, 1'b0, 100, 1'b1, e);
      build_exp(2048, 144, 100);
      t = 0;
      while (cap_i.size() < 500 && t < 3000) begin
         @(posedge clk); t++;
      end
      #1 reset = 1'b1;
      vec++;
      if (t >= 3000) begin
         miss++; $display("FAIL mid_timeout: got %0d samples want 500 within 3000 cycles", cap_i.size());
      end
      @(negedge clk);
      @(negedge clk);
      vec++;
      if ({dout_v, dout_h, dout_s} !== 3'b0 || dout_i !== '0) begin
         miss++; $display("FAIL mid_abort: got v/h/s=%b i=%h want 000/0", {dout_v, dout_h, dout_s}, dout_i);
      end
      bad = 0; first = -1;
      for (int k = 0; k < cap_i.size() && k < exp_i.size(); k++)
         if (cap_i[k] !== exp_i[k] || cap_q[k] !== exp_q[k]) begin
            bad++; if (first < 0) first = k;
         end
      vec++;
      if (bad != 0 || cap_i.size() != 501) begin
         miss++; $display("FAIL mid_prefix: got %0d samples %0d bad want 501 with 0 bad", cap_i.size(), bad);
      end
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      clear_cap();
      idle(20);
      vec++;
      if (cap_i.size() != 0) begin
         miss++; $display("FAIL mid_stale: got %0d samples after reset want 0", cap_i.size());
      end
      fft_num = 3'd4; cp_type = 1'b1;
      send_sym(128, 1'b1, 50, 1'b1, e);
      build_exp(128, 32, 50);
      repeat (200) @(posedge clk);
      c0 = (cap_cyc.size() > 0) ? cap_cyc[0] : -1;
      vec++;
      if (cap_i.size() != 160 || c0 != e + 3) begin
         miss++; $display("FAIL mid_fresh: got %0d samples first at %0d want 160 at %0d", cap_i.size(), c0, e + 3);
      end
      bad = 0; first = -1;
      for (int k = 0; k < cap_i.size() && k < exp_i.size(); k++)
         if (cap_i[k] !== exp_i[k] || cap_q[k] !== exp_q[k] || cap_s[k] !== 1'b1) begin
            bad++; if (first < 0) first = k;
         end
      vec++;
      if (bad != 0) begin
         miss++; $display("FAIL mid_fresh_data: %0d bad, first idx %0d got %h want %h", bad, first, cap_i[first], exp_i[first]);
      end
   endtask

   initial begin
`ifdef CP_INSERT_OVF_EN
      exp_ovf = 1'b1;
`else
      exp_ovf = 1'b0;
`endif
      test_reset();
      test_reset_defaults();
      test_ifft_2048();
      test_ifft_128_ext();
      test_back_to_back();
      test_overflow();
      test_fft_passthrough();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
